// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor for FPU mantissa and
// exponent arithmetic.
//
// Stage 1 registers the per-bit generate/propagate terms and the group
// generate/propagate terms. Stage 2 resolves the group carry chain and the
// in-group carries, then registers the result and its flags. Each stage
// advances on a valid/ready handshake, so the pipeline stalls without
// dropping or duplicating beats.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid      operand beat valid
//   in_ready      block can accept a beat this cycle (combinational)
//   in_a, in_b    operands
//   in_ci         carry-in (inverted in subtract mode)
//   in_sub        1 = A-B, 0 = A+B
//   out_valid     result beat valid
//   out_ready     downstream accepts the result
//   out_sum       result, modulo 2^WIDTH
//   out_co        carry-out of the MSB (subtract: 1 = no borrow)
//   out_ovf       two's-complement signed overflow
//   out_zero      out_sum == 0
module cla_add_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned NGRP = WIDTH / GROUP;

    // Effective operands: subtraction is A + ~B with the carry-in inverted.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;

    assign b_eff = in_sub ? ~in_b : in_b;
    assign c_eff = in_ci ^ in_sub;
    assign g_bit = in_a & b_eff;
    assign p_bit = in_a ^ b_eff;

    // Group generate/propagate: ripple each group's g/p from its LSB upward.
    logic [NGRP-1:0] g_grp;
    logic [NGRP-1:0] p_grp;

    always_comb begin
        logic gx_acc;
        logic px_acc;
        g_grp = '0;
        p_grp = '0;
        for (int j = 0; j < int'(NGRP); j++) begin
            gx_acc = 1'b0;
            px_acc = 1'b1;
            for (int k = 0; k < int'(GROUP); k++) begin
                gx_acc = g_bit[j*GROUP + k] | (p_bit[j*GROUP + k] & gx_acc);
                px_acc = px_acc & p_bit[j*GROUP + k];
            end
            g_grp[j] = gx_acc;
            p_grp[j] = px_acc;
        end
    end

    // Stage 1 registers.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic [NGRP-1:0]  s1_gx;
    logic [NGRP-1:0]  s1_px;
    logic             s1_c;
    logic             s1_a_msb;
    logic             s1_b_msb;

    logic s2_ready;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    // Stage 1 load: takes a new beat (or a bubble) whenever it can move on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_gx    <= '0;
            s1_px    <= '0;
            s1_c     <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_g     <= g_bit;
                s1_p     <= p_bit;
                s1_gx    <= g_grp;
                s1_px    <= p_grp;
                s1_c     <= c_eff;
                s1_a_msb <= in_a[WIDTH-1];
                s1_b_msb <= b_eff[WIDTH-1];
            end
        end
    end

    // Group carry chain, then in-group carries seeded by each group carry.
    // The carry out of every group comes from the lookahead chain, not the
    // in-group ripple.
    logic [NGRP:0]    c_grp;
    logic [WIDTH:0]   c_bit;
    logic [WIDTH-1:0] sum_nxt;
    logic             ovf_nxt;

    always_comb begin
        c_grp    = '0;
        c_grp[0] = s1_c;
        for (int j = 0; j < int'(NGRP); j++) begin
            c_grp[j+1] = s1_gx[j] | (s1_px[j] & c_grp[j]);
        end

        c_bit = '0;
        for (int j = 0; j < int'(NGRP); j++) begin
            c_bit[j*GROUP] = c_grp[j];
            for (int k = 0; k < int'(GROUP) - 1; k++) begin
                c_bit[j*GROUP + k + 1] = s1_g[j*GROUP + k]
                                       | (s1_p[j*GROUP + k] & c_bit[j*GROUP + k]);
            end
        end
        c_bit[WIDTH] = c_grp[NGRP];
    end

    assign sum_nxt = s1_p ^ c_bit[WIDTH-1:0];
    assign ovf_nxt = (s1_a_msb == s1_b_msb) && (sum_nxt[WIDTH-1] != s1_a_msb);

    // Stage 2 output registers: hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= sum_nxt;
                out_co   <= c_bit[WIDTH];
                out_ovf  <= ovf_nxt;
                out_zero <= ~|sum_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cla_add_pipe.sv
module tb_cla_add_pipe;

    typedef struct packed {
        logic [63:0] sum;
        logic        co;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // 32-bit side, shared by three GROUP variants
    logic        v32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        ci32 = 1'b0;
    logic        sub32 = 1'b0;
    logic        ordy32 = 1'b1;
    logic [2:0]  ir32;
    logic [2:0]  ov32;
    logic [2:0]  co32;
    logic [2:0]  of32;
    logic [2:0]  zr32;
    logic [31:0] sm32 [3];

    // 64-bit side
    logic        v64 = 1'b0;
    logic [63:0] a64 = '0;
    logic [63:0] b64 = '0;
    logic        ci64 = 1'b0;
    logic        sub64 = 1'b0;
    logic        ordy64 = 1'b1;
    logic        ir64;
    logic        ov64;
    logic        co64;
    logic        of64;
    logic        zr64;
    logic [63:0] sm64;

    cla_add_pipe #(.WIDTH(32), .GROUP(8)) u_g8 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32[0]),
        .in_a(a32), .in_b(b32), .in_ci(ci32), .in_sub(sub32),
        .out_valid(ov32[0]), .out_ready(ordy32), .out_sum(sm32[0]),
        .out_co(co32[0]), .out_ovf(of32[0]), .out_zero(zr32[0]));

    cla_add_pipe #(.WIDTH(32), .GROUP(2)) u_g2 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32[1]),
        .in_a(a32), .in_b(b32), .in_ci(ci32), .in_sub(sub32),
        .out_valid(ov32[1]), .out_ready(ordy32), .out_sum(sm32[1]),
        .out_co(co32[1]), .out_ovf(of32[1]), .out_zero(zr32[1]));

    cla_add_pipe #(.WIDTH(32), .GROUP(4)) u_g4 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32[2]),
        .in_a(a32), .in_b(b32), .in_ci(ci32), .in_sub(sub32),
        .out_valid(ov32[2]), .out_ready(ordy32), .out_sum(sm32[2]),
        .out_co(co32[2]), .out_ovf(of32[2]), .out_zero(zr32[2]));

    cla_add_pipe #(.WIDTH(64), .GROUP(4)) u_w64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(ir64),
        .in_a(a64), .in_b(b64), .in_ci(ci64), .in_sub(sub64),
        .out_valid(ov64), .out_ready(ordy64), .out_sum(sm64),
        .out_co(co64), .out_ovf(of64), .out_zero(zr64));

    int n_assert = 0;
    int n_fail   = 0;

    // Occupancy model of the two stages plus in-order scoreboards
    logic m1_32 = 1'b0, m2_32 = 1'b0, m1_64 = 1'b0, m2_64 = 1'b0;
    exp_t q32[$];
    exp_t q64[$];
    logic acc32, acc64;

    task automatic chk(input string tag, input int id,
                       input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, id, obs, expv);
        end
    endtask

    function automatic exp_t model(input int w, input logic [63:0] a,
                                   input logic [63:0] b, input logic ci,
                                   input logic sub);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] beff;
        logic [64:0] full;
        exp_t e;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        beff = (sub ? ~b : b) & mask;
        full = {1'b0, am} + {1'b0, beff} + 65'(ci ^ sub);
        e.sum  = full[63:0] & mask;
        e.co   = full[w];
        e.zero = (e.sum == 64'd0);
        e.ovf  = (am[w-1] == beff[w-1]) && (e.sum[w-1] != am[w-1]);
        return e;
    endfunction

    // One clock: check both sides mid-cycle, update models, step past the edge.
    task automatic cycle();
        logic er;
        logic s2r;
        @(negedge clk);
        // 32-bit side
        s2r = !m2_32 || ordy32;
        er  = !m1_32 || s2r;
        for (int d = 0; d < 3; d++) begin
            chk("in_ready32", d, 64'(ir32[d]), 64'(er));
            chk("out_valid32", d, 64'(ov32[d]), 64'(m2_32));
            if (m2_32 && q32.size() > 0) begin
                chk("sum32", d, 64'(sm32[d]), q32[0].sum);
                chk("co32", d, 64'(co32[d]), 64'(q32[0].co));
                chk("ovf32", d, 64'(of32[d]), 64'(q32[0].ovf));
                chk("zero32", d, 64'(zr32[d]), 64'(q32[0].zero));
            end
        end
        acc32 = v32 && er;
        if (m2_32 && ordy32 && q32.size() > 0) void'(q32.pop_front());
        if (acc32) q32.push_back(model(32, 64'(a32), 64'(b32), ci32, sub32));
        m2_32 = s2r ? m1_32 : m2_32;
        m1_32 = er ? v32 : m1_32;
        // 64-bit side
        s2r = !m2_64 || ordy64;
        er  = !m1_64 || s2r;
        chk("in_ready64", 0, 64'(ir64), 64'(er));
        chk("out_valid64", 0, 64'(ov64), 64'(m2_64));
        if (m2_64 && q64.size() > 0) begin
            chk("sum64", 0, sm64, q64[0].sum);
            chk("co64", 0, 64'(co64), 64'(q64[0].co));
            chk("ovf64", 0, 64'(of64), 64'(q64[0].ovf));
            chk("zero64", 0, 64'(zr64), 64'(q64[0].zero));
        end
        acc64 = v64 && er;
        if (m2_64 && ordy64 && q64.size() > 0) void'(q64.pop_front());
        if (acc64) q64.push_back(model(64, a64, b64, ci64, sub64));
        m2_64 = s2r ? m1_64 : m2_64;
        m1_64 = er ? v64 : m1_64;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_out_valid32", d, 64'(ov32[d]), 64'd0);
            chk("rst_sum32", d, 64'(sm32[d]), 64'd0);
            chk("rst_flags32", d, 64'({co32[d], of32[d], zr32[d]}), 64'd0);
        end
        chk("rst_out_valid64", 0, 64'(ov64), 64'd0);
        chk("rst_sum64", 0, sm64, 64'd0);
        chk("rst_flags64", 0, 64'({co64, of64, zr64}), 64'd0);
        m1_32 = 1'b0; m2_32 = 1'b0; m1_64 = 1'b0; m2_64 = 1'b0;
        q32.delete();
        q64.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sub);
        int n;
        a32 = a; b32 = b; ci32 = ci; sub32 = sub; v32 = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!acc32 && n < 20);
        if (!acc32) chk("send32_timeout", 0, 64'd0, 64'd1);
        v32 = 1'b0;
    endtask

    task automatic drain();
        int n;
        ordy32 = 1'b1;
        ordy64 = 1'b1;
        n = 0;
        while ((m1_32 || m2_32 || m1_64 || m2_64) && n < 50) begin
            cycle();
            n++;
        end
        if (m1_32 || m2_32 || m1_64 || m2_64) chk("drain_timeout", 0, 64'd0, 64'd1);
        chk("q32_empty", 0, 64'(q32.size()), 64'd0);
        chk("q64_empty", 0, 64'(q64.size()), 64'd0);
    endtask

    function automatic logic [63:0] rand_op();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'd0;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int beats;
        do_reset();
        cycle();

        // Directed corners, back-to-back with a free-running consumer
        ordy32 = 1'b1;
        send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send32(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send32(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        send32(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
        send32(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        send32(32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 1'b0);
        send32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        drain();

        // Backpressure: fill the pipe, hold a third beat, then release
        ordy32 = 1'b0;
        send32(32'd1, 32'h10, 1'b0, 1'b0);
        send32(32'd2, 32'h10, 1'b0, 1'b0);
        a32 = 32'd3; b32 = 32'h10; ci32 = 1'b0; sub32 = 1'b0; v32 = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_sum", 0, 64'(sm32[0]), 64'h11);
        ordy32 = 1'b1;
        send32(32'd3, 32'h10, 1'b0, 1'b0);
        send32(32'd4, 32'h10, 1'b0, 1'b0);
        drain();

        // Reset with two beats in flight; nothing stale may reappear
        ordy32 = 1'b0;
        send32(32'h55, 32'h01, 1'b0, 1'b0);
        send32(32'h66, 32'h01, 1'b0, 1'b0);
        do_reset();
        ordy32 = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Random traffic on the 64-bit / GROUP=4 instance
        beats = 0;
        n = 0;
        v64 = 1'b0;
        while (beats < 10000 && n < 40000) begin
            if (!v64 || acc64) begin
                v64   = ($urandom_range(0, 3) != 0);
                a64   = rand_op();
                b64   = rand_op();
                ci64  = 1'($urandom_range(0, 1));
                sub64 = 1'($urandom_range(0, 1));
            end
            ordy64 = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc64) beats++;
            n++;
        end
        if (beats < 10000) chk("random_timeout", 0, 64'(beats), 64'd10000);
        v64 = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_add_pipe.md
Name: cla_add_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the FPU datapath, used for mantissa and exponent arithmetic.
- Builds a two-level lookahead: per-bit generate/propagate, then GROUP-bit groups, then a group-level carry chain.
- Registered in two stages with a valid/ready handshake, so it stalls cleanly under downstream backpressure.
- Adds subtract mode and result flags: carry-out, signed overflow, zero.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of GROUP, minimum 8.
- GROUP, 8, bits per lookahead group; legal values 2, 4, 8.
- NGRP, WIDTH/GROUP, derived local parameter; number of groups. Not overridable.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_ci  input  1  carry-in. In subtract mode it is XORed with 1.
- in_sub  input  1  1 = A-B (B inverted), 0 = A+B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  result.
- out_co  output  1  carry-out of MSB. In subtract mode, 1 means no borrow.
- out_ovf  output  1  two's-complement signed overflow.
- out_zero  output  1  out_sum == 0.

Behaviour:
- Reset (async assert, sync deassert internally not required):
  - s1_valid=0, out_valid=0.
  - out_sum=0, out_co=0, out_ovf=0, out_zero=0.
  - All stage registers=0.
  - in_ready is combinational and reads 1 immediately after reset.
- Effective operands:
  - b_eff = in_sub ? ~in_b : in_b.
  - c_eff = in_ci ^ in_sub.
  - Add with ci=1 gives A+B+1; subtract with ci=0 gives A-B; subtract with ci=1 gives A-B-1.
- Stage 1 (capture on in_valid && in_ready):
  - Register per-bit g=a&b_eff and p=a^b_eff (propagate is XOR so it can also be used for the sum).
  - Register group Gx/Px for each group: Gx = OR over k of (g[k] AND all p above k); Px = AND of all p in the group.
  - Register c_eff, a[MSB], b_eff[MSB].
- Stage 2 (advances when s1_valid && s2_ready):
  - Group carries: C_grp[0]=c_eff; C_grp[j+1]=Gx[j] | Px[j]&C_grp[j], flattened lookahead across groups.
  - In-group carries: c[i+1]=g[i] | p[i]&c[i], seeded by that group's C_grp.
  - Results: out_sum=p^c[WIDTH-1:0]; out_co=c[WIDTH].
  - out_ovf = (a_msb==b_eff_msb) && (out_sum[MSB]!=a_msb).
  - out_zero = ~|out_sum.
- Handshake:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready.
  - Latency: 2 cycles from accept to out_valid with no stall; throughput 1 beat/cycle.
- Output hold:
  - While out_valid && !out_ready, all out_* hold stable and the stage registers hold.
  - No beat is dropped or duplicated.
  - When the pipeline is full and stalled, in_ready=0.
- Simultaneous events:
  - Same-cycle output consume and input accept both happen; the pipeline shifts.
  - in_valid while in_ready=0: the beat is ignored; the source must hold it.
- Reset mid-operation: all in-flight beats are discarded, out_valid drops in the same cycle as rst assertion, and nothing is replayed.
- Width rules:
  - Unsigned carry-out is independent of ovf.
  - Sum wraps modulo 2^WIDTH.

Test Plan:
- WIDTH=32, add, A=0xFFFFFFFF, B=0x00000001, ci=0, out_ready=1 -> 2 cycles later: sum=0x00000000, co=1, zero=1, ovf=0.
- Subtract, A=0x80000000, B=0x00000001, ci=0 -> sum=0x7FFFFFFF, co=1, ovf=1, zero=0. Then A=0x00000000, B=0x00000001 -> sum=0xFFFFFFFF, co=0, ovf=0.
- Full group ripple: add A=0x7FFFFFFF, B=0, ci=1 -> sum=0x80000000, co=0, ovf=1. Repeat with GROUP=2 and GROUP=4 for the same result.
- Backpressure:
  - Send 4 back-to-back beats (A=1,2,3,4; B=0x10) with out_ready=0.
  - Required: in_ready falls after 2 accepts; out_sum holds 0x11 stable.
  - Release out_ready -> sums 0x11, 0x12, 0x13, 0x14 in order, each exactly once.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0 and all outputs 0 immediately; after deassert in_ready=1 and no stale beat appears.
- Random: WIDTH=64, GROUP=4, 10k beats, random in_valid/out_ready toggling, checked against a behavioural A±B±ci model. Covers sum, co, ovf, zero and in-order delivery.
